// File: rtl/aes_128_in_pack.sv
// Input packing stage for aes_128_top: gathers 32-bit plaintext words into
// 128-bit blocks (word 0 in bits [127:96]) and queues them in a small FIFO.
module aes_128_in_pack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_sof,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [127:0]      m_data,
    output logic [CNT_W-1:0]  level,
    output logic              err_frag
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BLK_W  = 128;

    logic [1:0]        wcnt;
    logic [WORD_W-1:0] lane0;
    logic [WORD_W-1:0] lane1;
    logic [WORD_W-1:0] lane2;
    logic [BLK_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic full_c;
    logic word_fire_c;
    logic restart_c;
    logic push_c;
    logic pop_c;

    // Handshake qualification; flush masks both sides of the stage.
    assign full_c      = (count == CNT_W'(DEPTH));
    assign s_ready     = !((wcnt == 2'd3) && full_c);
    assign m_valid     = (count != '0);
    assign m_data      = mem[rd_ptr];
    assign level       = count;
    assign word_fire_c = s_valid && s_ready && !flush;
    assign restart_c   = word_fire_c && s_sof && (wcnt != 2'd0);
    assign push_c      = word_fire_c && !restart_c && (wcnt == 2'd3);
    assign pop_c       = m_valid && m_ready && !flush;

    // Assembly lanes; a misplaced start-of-frame restarts the block at lane 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt  <= 2'd0;
            lane0 <= '0;
            lane1 <= '0;
            lane2 <= '0;
        end else if (flush) begin
            wcnt <= 2'd0;
        end else if (word_fire_c) begin
            if (restart_c) begin
                lane0 <= s_data;
                wcnt  <= 2'd1;
            end else begin
                case (wcnt)
                    2'd0:    lane0 <= s_data;
                    2'd1:    lane1 <= s_data;
                    2'd2:    lane2 <= s_data;
                    default: ;
                endcase
                wcnt <= wcnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_frag <= 1'b0;
        end else begin
            err_frag <= restart_c;
        end
    end

    // FIFO bookkeeping; simultaneous push and pop keep the occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // The fourth word goes straight into the entry alongside lanes 0..2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push_c) begin
            mem[wr_ptr] <= {lane0, lane1, lane2, s_data};
        end
    end

endmodule

// File: tb/tb_aes_128_in_pack.sv
// Directed bench for aes_128_in_pack with a block scoreboard checked on every pop.
module tb_aes_128_in_pack;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_sof;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic [2:0]   level;
    logic         err_frag;

    logic [127:0] exp_q [$];
    logic [127:0] mon_exp;
    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_fail   = 0;

    aes_128_in_pack #(.DEPTH(4), .CNT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_sof    (s_sof),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .level    (level),
        .err_frag (err_frag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic sof);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        chk("s_ready_word", 128'(s_ready), 128'(1));
        tick();
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic send_block(input int k);
        exp_q.push_back({32'(k*4), 32'(k*4+1), 32'(k*4+2), 32'(k*4+3)});
        for (int i = 0; i < 4; i++) begin
            send_word(32'(k*4+i), i == 0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_ready = 1'b1;
        while (m_valid && n < 50) begin
            tick();
            n++;
        end
        m_ready = 1'b0;
        chk("drain_m_valid", 128'(m_valid), 128'(0));
        chk("drain_q_empty", 128'(exp_q.size()), 128'(0));
    endtask

    // Every accepted pop must match the oldest expected block.
    always @(negedge clk) begin
        if (!rst && !flush && m_valid && m_ready) begin
            mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            chk("pop_data", m_data, mon_exp);
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; m_ready = 1'b0;
        #2;
        chk("rst_s_ready", 128'(s_ready), 128'(1));
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_m_data", m_data, 128'(0));
        chk("rst_level", 128'(level), 128'(0));
        chk("rst_err_frag", 128'(err_frag), 128'(0));
        tick();
        rst = 1'b0;
        tick();

        // Single block
        exp_q.push_back(128'h00112233445566778899aabbccddeeff);
        send_word(32'h00112233, 1'b1);
        chk("single_no_err", 128'(err_frag), 128'(0));
        send_word(32'h44556677, 1'b0);
        send_word(32'h8899aabb, 1'b0);
        chk("single_not_yet", 128'(m_valid), 128'(0));
        send_word(32'hccddeeff, 1'b0);
        chk("single_m_valid", 128'(m_valid), 128'(1));
        chk("single_m_data", m_data, 128'h00112233445566778899aabbccddeeff);
        chk("single_level", 128'(level), 128'(1));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("single_level_pop", 128'(level), 128'(0));
        chk("single_empty", 128'(m_valid), 128'(0));

        // Fill to full, then drain across the pointer wrap
        for (int k = 0; k < 4; k++) send_block(k);
        chk("full_level", 128'(level), 128'(4));
        exp_q.push_back({32'd16, 32'd17, 32'd18, 32'd19});
        send_word(32'd16, 1'b1);
        send_word(32'd17, 1'b0);
        send_word(32'd18, 1'b0);
        s_valid = 1'b1; s_data = 32'd19; s_sof = 1'b0;
        chk("full_w3_blocked", 128'(s_ready), 128'(0));
        tick();
        chk("full_w3_still_blocked", 128'(s_ready), 128'(0));
        m_ready = 1'b1;
        chk("boundary_ready_low", 128'(s_ready), 128'(0));
        tick();
        chk("boundary_ready_next", 128'(s_ready), 128'(1));
        chk("boundary_level", 128'(level), 128'(3));
        tick();
        s_valid = 1'b0;
        chk("boundary_push_pop_level", 128'(level), 128'(3));
        drain();

        // Simultaneous push and pop at level 2
        send_block(5);
        send_block(6);
        chk("pp_level_before", 128'(level), 128'(2));
        exp_q.push_back({32'd28, 32'd29, 32'd30, 32'd31});
        send_word(32'd28, 1'b1);
        send_word(32'd29, 1'b0);
        send_word(32'd30, 1'b0);
        m_ready = 1'b1;
        send_word(32'd31, 1'b0);
        m_ready = 1'b0;
        chk("pp_level_after", 128'(level), 128'(2));
        drain();

        // Fragment recovery
        send_word(32'ha0a0a0a0, 1'b1);
        send_word(32'ha1a1a1a1, 1'b0);
        chk("frag_no_err_yet", 128'(err_frag), 128'(0));
        exp_q.push_back(128'hc0c0c0c0_c1c1c1c1_c2c2c2c2_c3c3c3c3);
        send_word(32'hc0c0c0c0, 1'b1);
        chk("frag_pulse", 128'(err_frag), 128'(1));
        send_word(32'hc1c1c1c1, 1'b0);
        chk("frag_pulse_once", 128'(err_frag), 128'(0));
        send_word(32'hc2c2c2c2, 1'b0);
        chk("frag_not_yet", 128'(m_valid), 128'(0));
        send_word(32'hc3c3c3c3, 1'b0);
        chk("frag_level", 128'(level), 128'(1));
        chk("frag_block", m_data, 128'hc0c0c0c0_c1c1c1c1_c2c2c2c2_c3c3c3c3);
        drain();

        // Flush with level 3 and two words pending
        send_block(8);
        send_block(9);
        send_block(10);
        chk("flush_level_before", 128'(level), 128'(3));
        send_word(32'h11111111, 1'b1);
        send_word(32'h22222222, 1'b0);
        flush = 1'b1; s_valid = 1'b1; s_data = 32'hdeadbeef; m_ready = 1'b1;
        tick();
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        exp_q.delete();
        chk("flush_m_valid", 128'(m_valid), 128'(0));
        chk("flush_level", 128'(level), 128'(0));
        chk("flush_s_ready", 128'(s_ready), 128'(1));
        chk("flush_no_err", 128'(err_frag), 128'(0));
        exp_q.push_back(128'h33333333_44444444_55555555_66666666);
        send_word(32'h33333333, 1'b0);
        send_word(32'h44444444, 1'b0);
        send_word(32'h55555555, 1'b0);
        send_word(32'h66666666, 1'b0);
        chk("flush_next_level", 128'(level), 128'(1));
        drain();

        // Asynchronous reset mid-stream
        send_block(12);
        send_block(13);
        send_word(32'h77777777, 1'b1);
        chk("arst_level_before", 128'(level), 128'(2));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_m_valid", 128'(m_valid), 128'(0));
        chk("arst_level", 128'(level), 128'(0));
        chk("arst_s_ready", 128'(s_ready), 128'(1));
        chk("arst_m_data", m_data, 128'(0));
        chk("arst_err_frag", 128'(err_frag), 128'(0));
        exp_q.delete();
        tick();
        #2;
        rst = 1'b0;
        tick();
        chk("arst_no_stale", 128'(m_valid), 128'(0));
        chk("arst_level_after", 128'(level), 128'(0));
        exp_q.push_back(128'h88888888_99999999_aaaaaaaa_bbbbbbbb);
        send_word(32'h88888888, 1'b0);
        send_word(32'h99999999, 1'b0);
        send_word(32'haaaaaaaa, 1'b0);
        send_word(32'hbbbbbbbb, 1'b0);
        chk("arst_fresh_block", m_data, 128'h88888888_99999999_aaaaaaaa_bbbbbbbb);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
